// File: rtl/kernel_raster_writer.sv
// Raster writer: emits a WIDTH x DEPTH frame, kernel border filled with a constant and
// interior pixels drawn from an input FIFO. Optional macro KRW_BORDER_VALUE_EN adds border_value.
module kernel_raster_writer #(
  parameter int WIDTH       = 640,
  parameter int DEPTH       = 512,
  parameter int KERNEL_SIZE = 3,
  parameter int DATA_WIDTH  = 16,
  parameter int FIFO_DEPTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  in_ready,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_sof,
  output logic                  out_eol,
  output logic                  out_eof,
  output logic                  frame_done,
  output logic                  overflow
`ifdef KRW_BORDER_VALUE_EN
  ,
  input  logic [DATA_WIDTH-1:0] border_value
`endif
);

  localparam int B  = (KERNEL_SIZE - 1) / 2;
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int RW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  typedef enum logic [2:0] {IDLE, TOP, MID, BOTTOM, DONE} state_t;

  state_t                state;
  logic [RW-1:0]         row;
  logic [CW-1:0]         col;
  logic                  last_sent;
  logic [DATA_WIDTH-1:0] bval;
  logic [DATA_WIDTH-1:0] start_bval;

  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]         wr_ptr;
  logic [AW-1:0]         rd_ptr;
  logic [AW:0]           count;
  logic                  fifo_empty;
  logic                  fifo_full;
  logic                  push;
  logic                  pop;
  logic                  start_acc;

  logic                  gen_active_p0;
  logic                  interior_p0;
  logic                  row_end_p0;
  logic                  last_pix_p0;
  logic                  load_p0;
  logic [DATA_WIDTH-1:0] pix_p0;

  function automatic logic is_border(input logic [RW-1:0] r, input logic [CW-1:0] c);
    return (int'(r) < B) || (int'(r) >= DEPTH - B) || (int'(c) < B) || (int'(c) >= WIDTH - B);
  endfunction

`ifdef KRW_BORDER_VALUE_EN
  assign start_bval = border_value;
`else
  assign start_bval = '0;
`endif

  assign start_acc  = start && (state == IDLE);
  assign fifo_empty = (count == '0);
  assign fifo_full  = (count == (AW+1)'(FIFO_DEPTH));
  assign in_ready   = !fifo_full;
  // A push is refused whenever the FIFO is full, even if a pop happens in the same cycle.
  assign push       = in_valid && !fifo_full;
  assign pop        = load_p0 && interior_p0;

  // Stage p0: pick the pixel at (row, col) and decide whether the output register can take it.
  always_comb begin
    gen_active_p0 = ((state == TOP) || (state == MID) || (state == BOTTOM)) && !last_sent;
    interior_p0   = (state == MID) && !is_border(row, col);
    row_end_p0    = (col == CW'(WIDTH - 1));
    last_pix_p0   = row_end_p0 && (row == RW'(DEPTH - 1));
    load_p0       = gen_active_p0 && (!out_valid || out_ready) && (!interior_p0 || !fifo_empty);
    pix_p0        = interior_p0 ? mem[rd_ptr] : bval;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (start_acc) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (!push && pop) count <= count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= in_data;
  end

  // Stage p1: output register, sequencing counters and frame FSM.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      row        <= '0;
      col        <= '0;
      last_sent  <= 1'b0;
      bval       <= '0;
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_sof    <= 1'b0;
      out_eol    <= 1'b0;
      out_eof    <= 1'b0;
      frame_done <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      frame_done <= 1'b0;

      if (start_acc)                   overflow <= 1'b0;
      else if (in_valid && fifo_full)  overflow <= 1'b1;

      // The accepting edge already loads pixel (0,0), which is always border.
      if (start_acc) begin
        out_valid <= 1'b1;
        out_data  <= start_bval;
        out_sof   <= 1'b1;
        out_eol   <= 1'b0;
        out_eof   <= 1'b0;
      end else if (load_p0) begin
        out_valid <= 1'b1;
        out_data  <= pix_p0;
        out_sof   <= (row == '0) && (col == '0);
        out_eol   <= row_end_p0;
        out_eof   <= last_pix_p0;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end

      if (start_acc) begin
        row       <= '0;
        col       <= CW'(1);
        last_sent <= 1'b0;
      end else if (load_p0) begin
        if (last_pix_p0) begin
          row       <= '0;
          col       <= '0;
          last_sent <= 1'b1;
        end else if (row_end_p0) begin
          col <= '0;
          row <= row + 1'b1;
        end else begin
          col <= col + 1'b1;
        end
      end

      case (state)
        IDLE: begin
          if (start_acc) begin
            state <= TOP;
            bval  <= start_bval;
          end
        end
        TOP: begin
          if (load_p0 && row_end_p0 && (row == RW'(B - 1))) state <= MID;
        end
        MID: begin
          if (load_p0 && row_end_p0 && (row == RW'(DEPTH - B - 1))) state <= BOTTOM;
        end
        BOTTOM: begin
          // Frame ends only once the held end-of-frame pixel has been taken downstream.
          if (last_sent && out_valid && out_ready) begin
            state      <= DONE;
            frame_done <= 1'b1;
            last_sent  <= 1'b0;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_kernel_raster_writer.sv
// Randomized self-checking bench for kernel_raster_writer on a 6x4 frame, 3x3 kernel, 4-deep FIFO.
module tb_kernel_raster_writer;

  localparam int W  = 6;
  localparam int D  = 4;
  localparam int DW = 16;

  logic          clk;
  logic          rst_n;
  logic          start;
  logic          in_valid;
  logic [DW-1:0] in_data;
  logic          in_ready;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic          out_sof;
  logic          out_eol;
  logic          out_eof;
  logic          frame_done;
  logic          overflow;
`ifdef KRW_BORDER_VALUE_EN
  logic [DW-1:0] border_value;
`endif

  int            n_cmp;
  int            n_err;
  logic [DW-1:0] q_exp[$];
  int            px_idx;
  bit            ovf_exp;
  logic [DW-1:0] bval;

  kernel_raster_writer #(
    .WIDTH(W), .DEPTH(D), .KERNEL_SIZE(3), .DATA_WIDTH(DW), .FIFO_DEPTH(4)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_sof(out_sof), .out_eol(out_eol), .out_eof(out_eof),
    .frame_done(frame_done), .overflow(overflow)
`ifdef KRW_BORDER_VALUE_EN
    , .border_value(border_value)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check_val({tag, "_out_valid"}, out_valid, 0);
    check_val({tag, "_out_data"}, out_data, 0);
    check_val({tag, "_flags"}, {out_sof, out_eol, out_eof}, 0);
    check_val({tag, "_frame_done"}, frame_done, 0);
    check_val({tag, "_overflow"}, overflow, 0);
    check_val({tag, "_in_ready"}, in_ready, 1);
  endtask

  // Reference: pixel k of the frame is (k/W, k%W); border -> bval, else next pushed value.
  task automatic run_frame(input bit do_start, input int stop_at, input int rmode,
                           input int pmode, input int n_push);
    int            pushed, cyc, r, c;
    bit            prev_hold, done_exp, fin;
    logic [DW-1:0] prev_data, exp_d;
    pushed = 0; cyc = 0; prev_hold = 0; done_exp = 0; fin = 0; prev_data = '0;
    if (do_start) begin
      @(negedge clk);
`ifdef KRW_BORDER_VALUE_EN
      border_value = bval;
`endif
      start = 1; in_valid = 0; out_ready = 1;
      @(negedge clk);
      start = 0;
      q_exp.delete(); px_idx = 0; ovf_exp = 0;
      check_val("first_valid", out_valid, 1);
      check_val("first_sof", out_sof, 1);
      check_val("ovf_cleared", overflow, 0);
    end
    while (!fin && cyc < 3000) begin
      check_val("frame_done", frame_done, done_exp);
      if (done_exp) begin
        fin = 1;
        check_val("ovf_at_end", overflow, ovf_exp);
      end else if (px_idx == stop_at) begin
        break;
      end else begin
        if (prev_hold) begin
          check_val("hold_valid", out_valid, 1);
          check_val("hold_data", out_data, prev_data);
        end
        case (rmode)
          0:       out_ready = 1;
          1:       out_ready = (cyc % 2 == 0);
          default: out_ready = 1'($urandom_range(0, 1));
        endcase
        start = (rmode == 2) && ($urandom_range(0, 7) == 0);
        if (pushed < n_push && (pmode == 0 || $urandom_range(0, 1) == 1) && in_ready) begin
          in_valid = 1;
          in_data  = 16'($urandom);
          q_exp.push_back(in_data);
          pushed++;
        end else begin
          in_valid = 0;
        end
        if (out_valid && out_ready) begin
          r = px_idx / W;
          c = px_idx % W;
          if (r < 1 || r >= D - 1 || c < 1 || c >= W - 1) begin
            exp_d = bval;
          end else begin
            check_val("fifo_model_nonempty", q_exp.size() != 0, 1);
            exp_d = (q_exp.size() != 0) ? q_exp.pop_front() : '0;
          end
          check_val("pix_data", out_data, exp_d);
          check_val("pix_sof", out_sof, px_idx == 0);
          check_val("pix_eol", out_eol, c == W - 1);
          check_val("pix_eof", out_eof, px_idx == W * D - 1);
          if (px_idx == W * D - 1) done_exp = 1;
          px_idx++;
        end
        prev_hold = out_valid && !out_ready;
        prev_data = out_data;
        @(negedge clk);
        cyc++;
      end
    end
    start = 0;
    in_valid = 0;
    if (stop_at >= W * D) check_val("frame_complete", fin, 1);
  endtask

  initial begin
    n_cmp = 0; n_err = 0; px_idx = 0; ovf_exp = 0; bval = '0;
    rst_n = 0; start = 0; in_valid = 0; in_data = '0; out_ready = 0;
`ifdef KRW_BORDER_VALUE_EN
    border_value = '0;
`endif
    repeat (3) @(negedge clk);
    check_idle_outputs("reset");
    rst_n = 1;
    @(negedge clk);
    check_idle_outputs("post_reset");

    // Full-rate frame, then the same frame under 1,0 backpressure.
    run_frame(1, W * D, 0, 0, 8);
    run_frame(1, W * D, 1, 0, 8);
    // Random backpressure, random pushes, stray start pulses, and surplus input.
    run_frame(1, W * D, 2, 1, 8);
    run_frame(1, W * D, 2, 1, 8);
    run_frame(1, W * D, 2, 1, 10);

    // Empty FIFO: row 0 plus (1,0) go out, then the interior slot stalls.
    run_frame(1, 7, 0, 0, 0);
    check_val("stall_valid_low", out_valid, 0);
    in_valid = 1; in_data = 16'h0001; q_exp.push_back(in_data);
    @(negedge clk);
    in_valid = 0;
    check_val("latency_1cyc", out_valid, 0);
    @(negedge clk);
    check_val("latency_2cyc_valid", out_valid, 1);
    check_val("latency_2cyc_data", out_data, 16'h0001);
    run_frame(0, W * D, 0, 1, 7);

    // Overflow: stalled output, five pushes into a four-entry FIFO.
    @(negedge clk);
    start = 1; out_ready = 0; in_valid = 0;
    @(negedge clk);
    start = 0; q_exp.delete(); px_idx = 0; ovf_exp = 0;
    for (int i = 0; i < 5; i++) begin
      check_val("ovf_in_ready", in_ready, q_exp.size() < 4);
      in_valid = 1;
      in_data  = 16'(100 + i);
      if (in_ready) q_exp.push_back(in_data);
      @(negedge clk);
    end
    in_valid = 0;
    ovf_exp  = 1;
    check_val("ovf_set", overflow, 1);
    check_val("ovf_held_valid", out_valid, 1);
    check_val("ovf_held_sof", out_sof, 1);
    repeat (3) @(negedge clk);
    check_val("ovf_sticky", overflow, 1);
    run_frame(0, W * D, 0, 0, 4);
    run_frame(1, W * D, 2, 1, 8);

    // Reset mid-frame at pixel 10, then a clean frame.
    run_frame(1, 10, 2, 1, 8);
    out_ready = 0;
    rst_n = 0;
    #1;
    check_idle_outputs("midreset");
    repeat (2) @(negedge clk);
    check_idle_outputs("midreset_hold");
    rst_n = 1;
    run_frame(1, W * D, 0, 1, 8);

`ifdef KRW_BORDER_VALUE_EN
    bval = 16'hFFFF;
    run_frame(1, W * D, 1, 1, 8);
    bval = 16'h0000;
    run_frame(1, W * D, 0, 0, 8);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/kernel_raster_writer.md
KERNEL_RASTER_WRITER -- requirements
Module: kernel_raster_writer

Interface
REQ-001 Parameter WIDTH, 640, output frame columns.
REQ-002 Parameter DEPTH, 512, output frame rows.
REQ-003 Parameter KERNEL_SIZE, 3, odd kernel size; border thickness B = (KERNEL_SIZE-1)/2.
REQ-004 Parameter DATA_WIDTH, 16, pixel width.
REQ-005 Parameter FIFO_DEPTH, 16, input FIFO entries, power of two.
REQ-006 clk  in  1  clock; all state on its rising edge.
REQ-007 rst_n  in  1  reset, asynchronous, active-low.
REQ-008 start  in  1  frame-start pulse; accepted only in IDLE.
REQ-009 in_valid  in  1  interior result pixel present.
REQ-010 in_data  in  DATA_WIDTH  interior result pixel, raster order.
REQ-011 in_ready  out  1  high when FIFO not full.
REQ-012 out_valid  out  1  output pixel valid.
REQ-013 out_ready  in  1  downstream accepts pixel.
REQ-014 out_data  out  DATA_WIDTH  output pixel.
REQ-015 out_sof, out_eol, out_eof  out  1 each  first pixel of frame / last pixel of row / last pixel of frame, qualified by out_valid.
REQ-016 frame_done  out  1  one-cycle pulse after the last pixel is accepted.
REQ-017 overflow  out  1  sticky; set when in_valid is high while in_ready is low.

Function
REQ-018 The block SHALL emit exactly WIDTH*DEPTH pixels per frame in raster order and consume exactly (WIDTH-2B)*(DEPTH-2B) interior pixels from the FIFO.
REQ-019 Pixel (r,c) SHALL be border when r<B, r>=DEPTH-B, c<B or c>=WIDTH-B; border pixels SHALL be 0 and consume no FIFO entry.
REQ-020 FSM states: IDLE, TOP (r<B), MID, BOTTOM (r>=DEPTH-B), DONE.
REQ-021 Transitions: IDLE->TOP on start; TOP->MID after the last pixel of row B-1; MID->BOTTOM after row DEPTH-B-1; BOTTOM->DONE after the last pixel; DONE->IDLE after exactly one cycle.
REQ-022 The output stage SHALL be a single register that loads a new pixel only when out_valid=0 or out_ready=1.
REQ-023 Once asserted, out_valid and out_data SHALL hold until out_ready=1 is sampled.
REQ-024 An interior slot with the FIFO empty SHALL stall: out_valid drops after the held pixel is accepted, and no counter advances.
REQ-025 Column counter SHALL wrap WIDTH-1->0 and increment the row counter; the row counter SHALL wrap to 0 at DEPTH-1/WIDTH-1.
REQ-026 Latency: in TOP the first pixel SHALL be valid 1 cycle after start; an interior pixel written into an empty FIFO SHALL be visible at out_data 2 cycles after its push, when the output stage is free.
REQ-027 FIFO push SHALL occur on in_valid and in_ready; a push into a full FIFO SHALL be dropped and set overflow, even if a pop occurs in the same cycle.
REQ-028 start outside IDLE SHALL be ignored; the accepted start SHALL flush the FIFO and clear overflow.
REQ-029 Surplus interior pixels received after the last interior slot SHALL remain in the FIFO until the next accepted start.
REQ-030 out_sof/eol/eof SHALL be registered with out_data and follow the same hold rule.

Reset
REQ-031 Reset asserted at any time, including mid-frame, SHALL force IDLE, empty the FIFO, and clear the counters.
REQ-032 During and after reset, out_valid, out_data, out_sof, out_eol, out_eof, frame_done and overflow SHALL be 0, and in_ready SHALL be 1.

Configuration
REQ-033 With macro KRW_BORDER_VALUE_EN defined, the block SHALL add an input border_value[DATA_WIDTH-1:0], sampled at the accepted start and used for all border pixels of that frame.
REQ-034 Without KRW_BORDER_VALUE_EN, no such port SHALL exist and border pixels SHALL be 0.

Verification (WIDTH=6, DEPTH=4, KERNEL_SIZE=3, FIFO_DEPTH=4)
REQ-035 start; push 1..8 back-to-back; out_ready=1 -> 24 pixels, rows 0 0 0 0 0 0 / 0 1 2 3 4 0 / 0 5 6 7 8 0 / 0 0 0 0 0 0; sof on pixel 0; eol on pixels 5,11,17,23; eof on pixel 23; frame_done 1 cycle later.
REQ-036 Same frame with out_ready toggling 1,0 every cycle -> identical sequence, each pixel held stable while out_ready=0.
REQ-037 start with no input pushes -> 7 zero pixels emitted (row 0 plus pixel (1,0)), then out_valid=0; pushing 1 -> pixel (1,1)=1 appears 2 cycles after the push.
REQ-038 out_ready=0 after start; push 5 pixels -> the 5th is dropped, in_ready=0 after 4 pushes, overflow=1 and stays 1 until the next accepted start.
REQ-039 Reset asserted mid-frame at pixel 10, then start -> all outputs 0 during reset; the new frame begins with out_sof and no stale pixels.
REQ-040 With KRW_BORDER_VALUE_EN and border_value=16'hFFFF at start -> all 16 border pixels are FFFF, interior pixels unchanged.
